asr_init_seq: RTL and testbench

ASR_INIT_SEQ -- requirements
Module: asr_init_seq

---
 rtl/asr_seq_pkg.sv | 23 ++
 rtl/asr_seq_cnt.sv | 32 +++
 rtl/asr_init_seq.sv | 155 +++++++++++++++
 tb/tb_asr_init_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/asr_seq_pkg.sv
// Shared types and constants for the async set/reset init sequencer:
// state encoding, default sizing and the phase-counter width helper.
package asr_seq_pkg;

    localparam int ASR_DEF_WIDTH     = 8;
    localparam int ASR_DEF_PULSE_CYC = 2;
    localparam int ASR_DEF_RECOV_CYC = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATE  = 2'd1,
        ST_PULSE = 2'd2,
        ST_RECOV = 2'd3
    } asr_state_t;

    // Wide enough to hold the longer of the two timed phases.
    function automatic int asr_cnt_width(input int pulse_cyc, input int recov_cyc);
        int max_cyc;
        max_cyc = (pulse_cyc > recov_cyc) ? pulse_cyc : recov_cyc;
        return $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/asr_seq_cnt.sv
// Loadable down-counter that saturates at zero; zero flags that the
// current cycle is the last one of a timed phase.
module asr_seq_cnt #(
    parameter int CW = 2
) (
    input  logic          CLK,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    output logic          zero
);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (ld) begin
            cnt_next = ld_val;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    // No reset of its own: the parent loads the pulse length while in reset.
    always_ff @(posedge CLK) begin
        cnt_reg <= cnt_next;
    end

    // A phase loaded with N spends N cycles at values N..1.
    assign zero = (cnt_reg <= CW'(1));

endmodule

// File: rtl/asr_init_seq.sv
// Sequencer that gates the clock, pulses async set/reset pins to a captured
// pattern, waits out recovery and re-enables the bank. ERR logic exists only
// when ASR_INIT_SEQ_ERR_EN is defined.
module asr_init_seq
    import asr_seq_pkg::*;
#(
    parameter int WIDTH     = ASR_DEF_WIDTH,
    parameter int PULSE_CYC = ASR_DEF_PULSE_CYC,
    parameter int RECOV_CYC = ASR_DEF_RECOV_CYC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [WIDTH-1:0] PAT,
    output logic             ACK,
    output logic [WIDTH-1:0] RSTB_O,
    output logic [WIDTH-1:0] SETB_O,
    output logic             CKEN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int CW = asr_cnt_width(PULSE_CYC, RECOV_CYC);

    generate
        if (PULSE_CYC < 1) begin : g_bad_pulse
            $error("asr_init_seq: PULSE_CYC must be at least 1");
        end
        if (RECOV_CYC < 1) begin : g_bad_recov
            $error("asr_init_seq: RECOV_CYC must be at least 1");
        end
    endgenerate

    asr_state_t       state_reg, state_next;
    logic [WIDTH-1:0] pat_reg, pat_next;
    logic             accept;
    logic             cnt_ld;
    logic [CW-1:0]    cnt_ld_val;
    logic             cnt_zero;

    logic             ack_reg, ack_next;
    logic [WIDTH-1:0] rstb_reg, rstb_next;
    logic [WIDTH-1:0] setb_reg, setb_next;
    logic             cken_reg, cken_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             in_pulse_next;

    // Reset parks the FSM in PULSE with a full count, so release continues
    // straight into the remaining clear cycles.
    asr_seq_cnt #(.CW(CW)) u_cnt (
        .CLK    (CLK),
        .ld     (cnt_ld),
        .ld_val (cnt_ld_val),
        .zero   (cnt_zero)
    );

    assign accept = (state_reg == ST_RUN) && REQ;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_PULSE;
            pat_reg   <= '0;
            ack_reg   <= 1'b0;
            rstb_reg  <= '0;
            setb_reg  <= '1;
            cken_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pat_reg   <= pat_next;
            ack_reg   <= ack_next;
            rstb_reg  <= rstb_next;
            setb_reg  <= setb_next;
            cken_reg  <= cken_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pat_next   = accept ? PAT : pat_reg;
        cnt_ld     = RST;
        cnt_ld_val = CW'(PULSE_CYC);
        case (state_reg)
            ST_RUN: begin
                if (REQ) begin
                    state_next = ST_GATE;
                end
            end
            ST_GATE: begin
                state_next = ST_PULSE;
                cnt_ld     = 1'b1;
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    state_next = ST_RECOV;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = RST ? CW'(PULSE_CYC) : CW'(RECOV_CYC);
                end
            end
            ST_RECOV: begin
                if (cnt_zero) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_PULSE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every
    // output pin comes straight off a flop.
    always_comb begin
        ack_next      = accept;
        cken_next     = (state_next == ST_RUN);
        busy_next     = (state_next != ST_RUN);
        done_next     = (state_reg == ST_RECOV) && (state_next == ST_RUN);
        in_pulse_next = (state_next == ST_PULSE);
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pin
            assign rstb_next[gi] = in_pulse_next ? pat_next[gi]  : 1'b1;
            assign setb_next[gi] = in_pulse_next ? ~pat_next[gi] : 1'b1;
        end
    endgenerate

`ifdef ASR_INIT_SEQ_ERR_EN
    logic err_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_reg <= 1'b0;
        end else if (REQ && busy_reg) begin
            err_reg <= 1'b1;
        end
    end

    assign ERR = err_reg;
`else
    assign ERR = 1'b0;
`endif

    assign ACK    = ack_reg;
    assign RSTB_O = rstb_reg;
    assign SETB_O = setb_reg;
    assign CKEN   = cken_reg;
    assign BUSY   = busy_reg;
    assign DONE   = done_reg;

endmodule

// File: tb/tb_asr_init_seq.sv
// Self-checking bench for asr_init_seq against a phase-schedule model.
module tb_asr_init_seq;

    localparam int W   = 8;
    localparam int P   = 2;
    localparam int R   = 3;
    localparam int LAT = 2 + P + R;
`ifdef ASR_INIT_SEQ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         REQ = 1'b0;
    logic [W-1:0] PAT = '0;
    logic         ACK, CKEN, BUSY, DONE, ERR;
    logic [W-1:0] RSTB_O, SETB_O;

    asr_init_seq #(.WIDTH(W), .PULSE_CYC(P), .RECOV_CYC(R)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .PAT    (PAT),
        .ACK    (ACK),
        .RSTB_O (RSTB_O),
        .SETB_O (SETB_O),
        .CKEN   (CKEN),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ERR    (ERR)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: m_t counts cycles since the accepting edge. 0 = ack/gate,
    // 1..P = pulse, P+1..P+R = recovery, P+R+1 = done, beyond = idle.
    int           m_t   = 1;
    logic [W-1:0] m_pr  = '0;
    bit           m_err = 1'b0;

    wire [20:0] obs = {ACK, RSTB_O, SETB_O, CKEN, BUSY, DONE, ERR};

    task automatic model_edge();
        bit busy_now;
        if (RST) begin
            m_t   = 1;
            m_pr  = '0;
            m_err = 1'b0;
        end else begin
            busy_now = (m_t <= P + R);
            if (REQ && busy_now && ERR_EN) m_err = 1'b1;
            if (REQ && !busy_now) begin
                m_t  = 0;
                m_pr = PAT;
            end else if (m_t < 1000) begin
                m_t++;
            end
        end
    endtask

    function automatic logic [20:0] exp_vec();
        logic         pulse;
        logic [W-1:0] r, s;
        pulse = (m_t >= 1) && (m_t <= P);
        r = pulse ? m_pr  : 8'hFF;
        s = pulse ? ~m_pr : 8'hFF;
        return {m_t == 0, r, s, m_t > P + R, m_t <= P + R, m_t == P + R + 1, m_err};
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        cyc++;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [W-1:0] er;
        RST = 1'b1; REQ = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs !== {1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", obs, {1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        RST = 1'b0;
        for (int i = 0; i < 7; i++) begin
            er = (i < 2) ? 8'h00 : 8'hFF;
            checks++;
            if (RSTB_O !== er || SETB_O !== 8'hFF || CKEN !== (i >= 5) || BUSY !== (i < 5) ||
                DONE !== (i == 5) || ACK !== 1'b0) begin
                errors++;
                $display("FAIL reset_release[%0d]: got rstb=%h setb=%h cken=%b busy=%b done=%b ack=%b want rstb=%h setb=ff cken=%b busy=%b done=%b ack=0",
                         i, RSTB_O, SETB_O, CKEN, BUSY, DONE, ACK, er, i >= 5, i < 5, i == 5);
            end
            tick();
        end
        $display("TXN cyc=%0d reset release sequence", cyc);
    endtask

    task automatic test_single();
        logic [W-1:0] er, es;
        REQ = 1'b1; PAT = 8'hA5;
        tick();
        REQ = 1'b0;
        for (int i = 0; i < 8; i++) begin
            PAT = W'($urandom);
            er = (i == 1 || i == 2) ? 8'hA5 : 8'hFF;
            es = (i == 1 || i == 2) ? 8'h5A : 8'hFF;
            checks++;
            if (ACK !== (i == 0) || RSTB_O !== er || SETB_O !== es || CKEN !== (i >= 6) ||
                DONE !== (i == 6) || ERR !== m_err) begin
                errors++;
                $display("FAIL single_a5[%0d]: got ack=%b rstb=%h setb=%h cken=%b done=%b err=%b want ack=%b rstb=%h setb=%h cken=%b done=%b err=%b",
                         i, ACK, RSTB_O, SETB_O, CKEN, DONE, ERR, i == 0, er, es, i >= 6, i == 6, m_err);
            end
            tick();
        end
        $display("TXN cyc=%0d single request pat=a5", cyc);
    endtask

    task automatic test_busy_req();
        REQ = 1'b1; PAT = 8'h3C;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL busy_req[%0d]: got %h want %h", i, obs, exp_vec());
            end
            REQ = (i == 1 || i == 4);
            PAT = REQ ? 8'hFF : W'($urandom);
            tick();
        end
        REQ = 1'b0;
        checks++;
        if (ERR !== ERR_EN) begin
            errors++;
            $display("FAIL busy_req_err: got %b want %b", ERR, ERR_EN);
        end
        $display("TXN cyc=%0d request pat=3c with ignored mid-sequence requests", cyc);
    endtask

    task automatic test_mid_reset();
        REQ = 1'b1; PAT = 8'hC3;
        tick();
        REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL mid_reset_pre[%0d]: got %h want %h", i, obs, exp_vec());
            end
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (RSTB_O !== 8'h00 || SETB_O !== 8'hFF || CKEN !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: got rstb=%h setb=%h cken=%b err=%b want rstb=00 setb=ff cken=0 err=0",
                     RSTB_O, SETB_O, CKEN, ERR);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs !== exp_vec() || DONE !== (i == 5)) begin
                errors++;
                $display("FAIL mid_reset_seq[%0d]: got %h want %h (done want %b)", i, obs, exp_vec(), i == 5);
            end
            tick();
        end
        $display("TXN cyc=%0d reset abort during recovery", cyc);
    endtask

    task automatic test_back_to_back();
        int last_ack  = -1;
        int last_done = -1;
        REQ = 1'b1;
        for (int i = 0; i < 40; i++) begin
            PAT = W'($urandom);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_vec[%0d]: got %h want %h", i, obs, exp_vec());
            end
            if (DONE === 1'b1) last_done = cyc;
            if (ACK === 1'b1) begin
                if (last_ack >= 0) begin
                    checks++;
                    if (cyc - last_ack != LAT || cyc - last_done != 1) begin
                        errors++;
                        $display("FAIL b2b_spacing: got ack gap %0d done gap %0d want %0d and 1",
                                 cyc - last_ack, cyc - last_done, LAT);
                    end
                end
                last_ack = cyc;
                $display("TXN cyc=%0d back-to-back ack pat=%h", cyc, m_pr);
            end
        end
        REQ = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            RST = ($urandom_range(0, 499) == 0);
            REQ = ($urandom_range(0, 3) == 0);
            PAT = W'($urandom);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random_vec[%0d]: got %h want %h", i, obs, exp_vec());
            end
            checks++;
            if ((~RSTB_O & ~SETB_O) != '0) begin
                errors++;
                $display("FAIL random_both_low[%0d]: got rstb=%h setb=%h want no common zero bit", i, RSTB_O, SETB_O);
            end
            checks++;
            if (CKEN === 1'b1 && (RSTB_O != 8'hFF || SETB_O != 8'hFF)) begin
                errors++;
                $display("FAIL random_cken_pin[%0d]: got cken=1 with rstb=%h setb=%h want cken=0", i, RSTB_O, SETB_O);
            end
            if (ACK === 1'b1) $display("TXN cyc=%0d random ack pat=%h", cyc, m_pr);
        end
        RST = 1'b0;
        REQ = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; REQ = 1'b0; PAT = '0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_busy_req();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
